ddr_app_mem_model: RTL and testbench

//  Synthesizable, parametrised responder for the DDR MIG "app_*" native interface, with backing RAM.

---
 rtl/ddr_app_pkg.sv | 18 +
 rtl/ddr_model_sync_fifo.sv | 51 +++++
 rtl/ddr_app_mem_model.sv | 210 +++++++++++++++++++++
 tb/tb_ddr_app_mem_model.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_app_pkg.sv
// Shared definitions for the DDR MIG app_* responder model.
//   app_cmd_e  : native-interface command codes
//   LFSR_TAPS  : tap mask of the x^16+x^14+x^13+x^11 Fibonacci LFSR
//   lfsr_step  : one shift of that LFSR
package ddr_app_pkg;

  typedef enum logic [2:0] {
    APP_CMD_WR = 3'b000,
    APP_CMD_RD = 3'b001
  } app_cmd_e;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/ddr_model_sync_fifo.sv
// Show-ahead synchronous FIFO used for the command queue, the write-data
// FIFO and the optional read-return FIFO.
//   clk_i/rst_i : clock, synchronous active-high reset (clears pointers)
//   push_i/din_i: write side; a push on full is taken only with a pop
//   pop_i/dout_o: read side; dout_o is the head entry while !empty_o
//   full_o/empty_o/count_o : occupancy, evaluated before this clock's pop
module ddr_model_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       din_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/ddr_app_mem_model.sv
// Synthesizable responder for the DDR MIG app_* native interface with a
// backing RAM, LFSR back-pressure, fixed read latency and a calibration delay.
// Optional macro DDR_MODEL_RD_STALL_EN adds a read-return FIFO whose pops
// are gated by lfsr[0], giving random gaps in app_rd_data_valid.
//   clock, rst          : clock, synchronous active-high reset
//   app_addr/cmd/en/rdy : command channel (000 write, 001 read)
//   app_wdf_*           : write-data channel, one beat per burst, mask=1 skips byte
//   app_rd_data*        : read-return channel, no back-pressure
//   init_calib_complete : high CALIB_CYCLES clocks after reset release
//   model_err           : sticky protocol error flag
module ddr_app_mem_model
  import ddr_app_pkg::*;
#(
  parameter int          ADDR_WIDTH   = 27,
  parameter int          DATA_WIDTH   = 256,
  parameter int          MEM_AW       = 10,
  parameter int          ADDR_SHIFT   = 3,
  parameter int          CMD_DEPTH    = 16,
  parameter int          RD_LATENCY   = 15,
  parameter int          RDY_THRESH   = 128,
  parameter int          WDF_THRESH   = 128,
  parameter int          CALIB_CYCLES = 1000,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   app_addr,
  input  logic [2:0]              app_cmd,
  input  logic                    app_en,
  output logic                    app_rdy,
  input  logic [DATA_WIDTH-1:0]   app_wdf_data,
  input  logic [DATA_WIDTH/8-1:0] app_wdf_mask,
  input  logic                    app_wdf_wren,
  input  logic                    app_wdf_end,
  output logic                    app_wdf_rdy,
  output logic [DATA_WIDTH-1:0]   app_rd_data,
  output logic                    app_rd_data_valid,
  output logic                    app_rd_data_end,
  output logic                    init_calib_complete,
  output logic                    model_err
);
  localparam int BW = DATA_WIDTH / 8;
  localparam int CW = $clog2(CMD_DEPTH) + 1;
  localparam int KW = $clog2(CALIB_CYCLES + 1);

  typedef struct packed {
    logic              is_rd;
    logic [MEM_AW-1:0] idx;
  } cmd_t;

  typedef struct packed {
    logic [BW-1:0]         mask;
    logic [DATA_WIDTH-1:0] data;
  } wdf_t;

  logic [15:0]   lfsr_q;
  logic [KW-1:0] cnt_q, cnt_d;
  logic          calib_q, calib_d;
  logic          app_rdy_q, app_rdy_d, app_wdf_rdy_q, app_wdf_rdy_d;
  logic          err_q, err_d;

  cmd_t    cmd_in, cmd_head;
  wdf_t    wdf_in, wdf_head;
  logic    cmd_fire, cmd_ok, cmd_push, cmd_pop, cmdq_empty;
  logic    wdf_push, wdf_pop, wdf_empty;
  logic [CW-1:0] cmdq_cnt, wdf_cnt, cmdq_cnt_nxt, wdf_cnt_nxt;
  logic    exec_wr, exec_rd, rd_room;
  logic    unused_cmdq_full, unused_wdf_full, unused_addr;

  logic [DATA_WIDTH-1:0] mem_q [2**MEM_AW];
  logic [DATA_WIDTH-1:0] ram_rd_q;
  logic                  ram_v_q;
  logic                  pipe_v_q [RD_LATENCY];
  logic [DATA_WIDTH-1:0] pipe_d_q [RD_LATENCY];

  // Address bits outside the word index alias by design.
  assign unused_addr = ^app_addr;

  assign cmd_fire   = app_en && app_rdy_q;
  assign cmd_ok     = (app_cmd == APP_CMD_WR) || (app_cmd == APP_CMD_RD);
  assign cmd_push   = cmd_fire && cmd_ok;
  assign cmd_in     = '{is_rd: (app_cmd == APP_CMD_RD), idx: app_addr[ADDR_SHIFT +: MEM_AW]};
  assign wdf_push   = app_wdf_wren && app_wdf_end && app_wdf_rdy_q;
  assign wdf_in     = '{mask: app_wdf_mask, data: app_wdf_data};

  // In-order head execution; nothing executes in the reset cycle.
  assign exec_wr = !rst && !cmdq_empty && !cmd_head.is_rd && !wdf_empty;
  assign exec_rd = !rst && !cmdq_empty &&  cmd_head.is_rd && rd_room;
  assign cmd_pop = exec_wr || exec_rd;
  assign wdf_pop = exec_wr;

  ddr_model_sync_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_cmdq (
    .clk_i(clock), .rst_i(rst), .push_i(cmd_push), .din_i(cmd_in), .pop_i(cmd_pop),
    .dout_o(cmd_head), .full_o(unused_cmdq_full), .empty_o(cmdq_empty), .count_o(cmdq_cnt)
  );

  ddr_model_sync_fifo #(.WIDTH($bits(wdf_t)), .DEPTH(CMD_DEPTH)) u_wdf (
    .clk_i(clock), .rst_i(rst), .push_i(wdf_push), .din_i(wdf_in), .pop_i(wdf_pop),
    .dout_o(wdf_head), .full_o(unused_wdf_full), .empty_o(wdf_empty), .count_o(wdf_cnt)
  );

  // Ready is registered, so it is derived from next-cycle occupancy; a
  // handshake seen by the user can therefore never hit a full queue.
  always_comb begin
    cnt_d   = cnt_q;
    calib_d = calib_q;
    if (!calib_q) begin
      cnt_d   = cnt_q + KW'(1);
      calib_d = (cnt_q == KW'(CALIB_CYCLES - 1));
    end
    cmdq_cnt_nxt  = cmdq_cnt + CW'(cmd_push) - CW'(cmd_pop);
    wdf_cnt_nxt   = wdf_cnt + CW'(wdf_push) - CW'(wdf_pop);
    app_rdy_d     = calib_d && (cmdq_cnt_nxt < CW'(CMD_DEPTH)) &&
                    ({1'b0, lfsr_q[7:0]} < 9'(RDY_THRESH));
    app_wdf_rdy_d = calib_d && (wdf_cnt_nxt < CW'(CMD_DEPTH)) &&
                    ({1'b0, lfsr_q[15:8]} < 9'(WDF_THRESH));
    err_d = err_q | (cmd_fire && !cmd_ok) | (app_wdf_wren != app_wdf_end) |
            ((app_en || app_wdf_wren) && !calib_q);
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      lfsr_q        <= LFSR_SEED;
      cnt_q         <= '0;
      calib_q       <= 1'b0;
      app_rdy_q     <= 1'b0;
      app_wdf_rdy_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      lfsr_q        <= lfsr_step(lfsr_q);
      cnt_q         <= cnt_d;
      calib_q       <= calib_d;
      app_rdy_q     <= app_rdy_d;
      app_wdf_rdy_q <= app_wdf_rdy_d;
      err_q         <= err_d;
    end
  end

  // Backing RAM is never cleared.
  always_ff @(posedge clock) begin
    if (exec_wr) begin
      for (int unsigned b = 0; b < BW; b++) begin
        if (!wdf_head.mask[b]) mem_q[cmd_head.idx][b*8 +: 8] <= wdf_head.data[b*8 +: 8];
      end
    end
    if (exec_rd) ram_rd_q <= mem_q[cmd_head.idx];
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      ram_v_q <= 1'b0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) begin
        pipe_v_q[i] <= 1'b0;
        pipe_d_q[i] <= '0;
      end
    end else begin
      ram_v_q     <= exec_rd;
      pipe_v_q[0] <= ram_v_q;
      pipe_d_q[0] <= ram_rd_q;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        pipe_v_q[i] <= pipe_v_q[i-1];
        pipe_d_q[i] <= pipe_d_q[i-1];
      end
    end
  end

`ifdef DDR_MODEL_RD_STALL_EN
  logic [CW-1:0]         inflight_q, inflight_d, ret_cnt;
  logic                  ret_empty, ret_pop, unused_ret_full;
  logic [DATA_WIDTH-1:0] ret_head, rd_data_q;
  logic                  rd_valid_q;

  // Reads in flight plus those parked in the return FIFO never exceed its depth.
  assign rd_room    = ({1'b0, inflight_q} + {1'b0, ret_cnt}) < (CW+1)'(CMD_DEPTH);
  assign ret_pop    = !ret_empty && lfsr_q[0];
  assign inflight_d = inflight_q + CW'(exec_rd) - CW'(pipe_v_q[RD_LATENCY-1]);

  ddr_model_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(CMD_DEPTH)) u_ret (
    .clk_i(clock), .rst_i(rst), .push_i(pipe_v_q[RD_LATENCY-1]), .din_i(pipe_d_q[RD_LATENCY-1]),
    .pop_i(ret_pop), .dout_o(ret_head), .full_o(unused_ret_full), .empty_o(ret_empty),
    .count_o(ret_cnt)
  );

  always_ff @(posedge clock) begin
    if (rst) begin
      inflight_q <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      inflight_q <= inflight_d;
      rd_valid_q <= ret_pop;
      if (ret_pop) rd_data_q <= ret_head;
    end
  end

  assign app_rd_data_valid = rd_valid_q;
  assign app_rd_data       = rd_data_q;
`else
  assign rd_room           = 1'b1;
  assign app_rd_data_valid = pipe_v_q[RD_LATENCY-1];
  assign app_rd_data       = pipe_d_q[RD_LATENCY-1];
`endif

  assign app_rd_data_end     = app_rd_data_valid;
  assign app_rdy             = app_rdy_q;
  assign app_wdf_rdy         = app_wdf_rdy_q;
  assign init_calib_complete = calib_q;
  assign model_err           = err_q;

endmodule

// File: tb/tb_ddr_app_mem_model.sv
`timescale 1ns/1ps
module tb_ddr_app_mem_model;
  localparam int AW = 27, DW = 256, BW = 32, MAW = 10, SH = 3, RDL = 15, CALIB = 1000;

  logic          clock, rst;
  logic [AW-1:0] app_addr;
  logic [2:0]    app_cmd;
  logic          app_en, app_rdy;
  logic [DW-1:0] app_wdf_data;
  logic [BW-1:0] app_wdf_mask;
  logic          app_wdf_wren, app_wdf_end, app_wdf_rdy;
  logic [DW-1:0] app_rd_data;
  logic          app_rd_data_valid, app_rd_data_end, init_calib_complete, model_err;

  ddr_app_mem_model #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_AW(MAW), .ADDR_SHIFT(SH), .CMD_DEPTH(16),
    .RD_LATENCY(RDL), .RDY_THRESH(128), .WDF_THRESH(128), .CALIB_CYCLES(CALIB),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clock(clock), .rst(rst), .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
    .app_rdy(app_rdy), .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .app_rd_data_end(app_rd_data_end), .init_calib_complete(init_calib_complete),
    .model_err(model_err)
  );

  typedef struct { logic [DW-1:0] data; int cyc; } exp_t;
  typedef struct { logic [DW-1:0] data; logic [BW-1:0] mask; } beat_t;

  exp_t          exp_q[$];
  beat_t         wq[$];
  logic [DW-1:0] mdl [1024];
  int            checks = 0, errors = 0, cyc = 0, vld_cnt = 0;
  bit            data_hold = 0, bad_beat = 0;

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", nm);
  endtask

  function automatic logic [AW-1:0] mk_addr(input int idx, input int hi, input int lo);
    logic [AW-1:0] a;
    a = '0;
    a[SH +: MAW] = idx[MAW-1:0];
    a[SH+MAW +: (AW-SH-MAW)] = hi[AW-SH-MAW-1:0];
    a[SH-1:0] = lo[SH-1:0];
    return a;
  endfunction

  task automatic apply(input int idx, input logic [DW-1:0] d, input logic [BW-1:0] m);
    for (int b = 0; b < BW; b++) if (!m[b]) mdl[idx][b*8 +: 8] = d[b*8 +: 8];
  endtask

  // Monitor: pops the scoreboard whenever read data is presented.
  initial forever begin
    exp_t e;
    @(posedge clock); #1;
    if (!rst && app_rd_data_valid) begin
      vld_cnt++;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid: got data %h with no read outstanding", app_rd_data);
      end else begin
        e = exp_q.pop_front();
        chk("rd_data", app_rd_data, e.data);
        chk("rd_data_end", DW'(app_rd_data_end), DW'(1));
        if (e.cyc >= 0) chk("rd_latency_cycle", DW'(cyc), DW'(e.cyc));
      end
    end
  end

  // Write-data driver: sends queued beats in order, honouring data_hold.
  initial begin
    beat_t b;
    int n;
    app_wdf_wren = 0; app_wdf_end = 0; app_wdf_data = '0; app_wdf_mask = '0;
    forever begin
      if (bad_beat) begin
        app_wdf_wren = 1; app_wdf_end = 0;
        @(posedge clock); #1;
        app_wdf_wren = 0; bad_beat = 0;
      end else if (wq.size() > 0 && !data_hold && !rst) begin
        b = wq[0];
        app_wdf_data = b.data; app_wdf_mask = b.mask; app_wdf_wren = 1; app_wdf_end = 1;
        n = 0;
        while (!app_wdf_rdy && n < 2000) begin @(posedge clock); #1; n++; end
        if (!app_wdf_rdy) fail_now("wdf_timeout");
        else begin @(posedge clock); #1; end
        void'(wq.pop_front());
        app_wdf_wren = 0; app_wdf_end = 0;
      end else begin
        @(posedge clock); #1;
      end
    end
  end

  task automatic issue(input logic [2:0] cmd, input logic [AW-1:0] addr, output bit ok,
                       output int acc);
    int n = 0;
    app_cmd = cmd; app_addr = addr; app_en = 1;
    while (!app_rdy && n < 2000) begin @(posedge clock); #1; n++; end
    ok = app_rdy;
    acc = -1;
    if (!ok) fail_now("cmd_timeout");
    else begin @(posedge clock); #1; acc = cyc; end
    app_en = 0;
  endtask

  task automatic wr(input int idx, input int hi, input logic [DW-1:0] d, input logic [BW-1:0] m);
    bit ok; int acc;
    wq.push_back('{data: d, mask: m});
    issue(3'b000, mk_addr(idx, hi, hi), ok, acc);
    if (ok) apply(idx, d, m);
  endtask

  // use_model=0 takes the hand-computed constant; lat=1 also checks the valid cycle.
  task automatic rd(input int idx, input int hi, input bit use_model, input logic [DW-1:0] cexp,
                    input bit lat);
    bit ok; int acc; exp_t e;
    issue(3'b001, mk_addr(idx, hi, hi + 1), ok, acc);
    if (ok) begin
      e.data = use_model ? mdl[idx] : cexp;
      e.cyc  = lat ? acc + 1 + RDL : -1;
      exp_q.push_back(e);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || wq.size() != 0) && n < 5000) begin @(posedge clock); #1; n++; end
    if (n >= 5000) fail_now("drain_timeout");
    repeat (4) @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input bit poke);
    int n = 0, c0;
    bit rdy_early = 0;
    rst = 1;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_ctrl_outs", DW'({app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data_end,
                                init_calib_complete, model_err}), '0);
    chk("reset_rd_data", app_rd_data, '0);
    c0 = cyc;
    rst = 0;
    if (poke) begin app_en = 1; app_cmd = 3'b001; end
    while (!init_calib_complete && n < 1100) begin
      @(posedge clock); #1; n++;
      app_en = 0;
      if (!init_calib_complete && (app_rdy || app_wdf_rdy)) rdy_early = 1;
    end
    chk("calib_delay", DW'(cyc - c0), DW'(CALIB));
    chk("rdy_before_calib", DW'(rdy_early), '0);
    chk("err_after_calib", DW'(model_err), DW'(poke));
  endtask

  initial begin
    logic [DW-1:0] d, ones, a5, mexp;
    int rcnt, wcnt, pre;
    app_en = 0; app_cmd = '0; app_addr = '0; rst = 1;
    ones = '1;
    a5   = {32{8'hA5}};
    mexp = {{31{8'hFF}}, 8'h00};

    // Reset values and calibration delay.
    do_reset(0);

    // Write 0xA5.. to addr 0x40, read back-to-back, then an isolated latency read.
    wr(8, 0, a5, '0);
    rd(8, 0, 0, a5, 0);
    drain();
    rd(8, 0, 0, a5, 1);
    drain();

    // Byte mask: only byte 0 is overwritten.
    wr(3, 0, ones, '0);
    wr(3, 0, '0, 32'hFFFF_FFFE);
    rd(3, 0, 0, mexp, 0);
    drain();

    // Data delayed behind its commands; dependent reads must wait.
    data_hold = 1;
    for (int k = 0; k < 4; k++) wr(100 + k, k * 3, {8{32'h1111_0000 + k}}, '0);
    for (int k = 0; k < 4; k++) rd(100 + k, 7 - k, 1, '0, 0);
    pre = vld_cnt;
    repeat (20) @(posedge clock);
    #1;
    chk("no_valid_while_data_held", DW'(vld_cnt - pre), '0);
    data_hold = 0;
    drain();
    chk("held_reads_returned", DW'(vld_cnt - pre), DW'(4));

    // Random traffic with aliased addresses against the scoreboard.
    for (int j = 0; j < 16; j++) begin
      for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
      wr(16 + j * 61, $urandom_range(16383, 0), d, '0);
    end
    for (int i = 0; i < 1000; i++) begin
      int idx;
      idx = 16 + $urandom_range(15, 0) * 61;
      if ($urandom_range(1, 0) == 1) begin
        for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
        wr(idx, $urandom_range(16383, 0), d, ($urandom_range(3, 0) == 0) ? BW'($urandom) : '0);
      end else begin
        rd(idx, $urandom_range(16383, 0), 1, '0, 0);
      end
    end
    drain();

    // Ready duty over an idle window.
    rcnt = 0; wcnt = 0;
    repeat (2000) begin
      @(posedge clock); #1;
      rcnt += int'(app_rdy);
      wcnt += int'(app_wdf_rdy);
    end
    checks++;
    if (rcnt < 800 || rcnt > 1200) begin
      errors++; $display("FAIL app_rdy_duty: got %0d of 2000 expected 800..1200", rcnt);
    end
    checks++;
    if (wcnt < 800 || wcnt > 1200) begin
      errors++; $display("FAIL app_wdf_rdy_duty: got %0d of 2000 expected 800..1200", wcnt);
    end

    // Illegal command: sticky error, dropped, later reads unaffected.
    chk("err_clear_before_bad_cmd", DW'(model_err), '0);
    begin
      bit ok; int acc;
      issue(3'b011, mk_addr(3, 0, 0), ok, acc);
    end
    repeat (2) @(posedge clock);
    #1;
    chk("err_bad_cmd", DW'(model_err), DW'(1));
    rd(3, 5, 0, mexp, 0);
    drain();
    chk("err_sticky", DW'(model_err), DW'(1));

    // Reset clears the error but not RAM; wren without end is an error.
    do_reset(0);
    bad_beat = 1;
    repeat (3) @(posedge clock);
    #1;
    chk("err_wren_no_end", DW'(model_err), DW'(1));
    rd(3, 9, 0, mexp, 0);
    drain();

    // Command before calibration is an error.
    do_reset(1);
    rd(8, 1, 0, a5, 1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
